acorn_ad_process: RTL

- ACORN-128 associated-data (AD) phase.
- Sits directly downstream of the initialization stage. Takes that stage's 293-bit state after its 1792 steps.
- Absorbs a byte stream of AD one bit per cycle, then runs the 256-step AD padding.
- Presents the resulting state to the encryption stage.
- Each step is one instance of the shared state_update128 round.

---
 rtl/acorn_ad_process_pkg.sv | 23 ++
 rtl/state_update128.sv | 29 ++
 rtl/acorn_ad_process.sv | 104 ++++++++++
 3 files changed

// File: rtl/acorn_ad_process_pkg.sv
// acorn_ad_process_pkg: shared ACORN-128 constants, AD-phase FSM encoding and round helpers.
// Contents: state/pad/ca step counts, per-phase default ca/cb, maj/ch boolean helpers.
package acorn_ad_process_pkg;
  localparam int ACORN_STATE_W   = 293;
  localparam int ACORN_PAD_STEPS = 256;
  localparam int ACORN_CA_STEPS  = 128;
  localparam logic AD_CA  = 1'b1;
  localparam logic AD_CB  = 1'b1;
  localparam logic ENC_CB = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_AD_BITS,
    S_PAD,
    S_DONE
  } ad_state_e;
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction
endpackage

// File: rtl/state_update128.sv
// state_update128: one combinational ACORN-128 state-update step.
// Ports: i_state (current 293-bit state), i_mbit (message bit), i_ca/i_cb (control bits),
//        o_state (state after one step).
module state_update128
  import acorn_ad_process_pkg::*;
(
  input  logic [ACORN_STATE_W-1:0] i_state,
  input  logic                     i_mbit,
  input  logic                     i_ca,
  input  logic                     i_cb,
  output logic [ACORN_STATE_W-1:0] o_state
);
  logic [ACORN_STATE_W-1:0] w_s;
  logic                     w_ks;
  logic                     w_f;
  // LFSR folds are applied top-down so each reads the not-yet-updated lower tap.
  always_comb begin
    w_s      = i_state;
    w_s[289] = w_s[289] ^ w_s[235] ^ w_s[230];
    w_s[230] = w_s[230] ^ w_s[196] ^ w_s[193];
    w_s[193] = w_s[193] ^ w_s[160] ^ w_s[154];
    w_s[154] = w_s[154] ^ w_s[111] ^ w_s[107];
    w_s[107] = w_s[107] ^ w_s[66] ^ w_s[61];
    w_s[61]  = w_s[61] ^ w_s[23] ^ w_s[0];
    w_ks     = w_s[12] ^ w_s[154] ^ maj(w_s[235], w_s[61], w_s[193]) ^ ch(w_s[230], w_s[111], w_s[66]);
    w_f      = w_s[0] ^ ~w_s[107] ^ maj(w_s[244], w_s[23], w_s[160]) ^ (i_ca & w_s[196]) ^ (i_cb & w_ks);
    o_state  = {w_f ^ i_mbit, w_s[ACORN_STATE_W-1:1]};
  end
endmodule

// File: rtl/acorn_ad_process.sv
// acorn_ad_process: ACORN-128 associated-data absorption and 256-step AD padding.
// Ports: clk, rst (async active-high), start_i/ad_empty_i/state_in (phase load),
//        ad_valid_i/ad_data_i/ad_last_i/ad_ready_o (AD byte stream, LSB first),
//        state_out (state register), busy_o, done_o, ad_bitlen_o (absorbed AD bits).
// Optional: define ACORN_AD_LENCOUNT_EN to build the saturating 64-bit AD bit counter;
//           otherwise ad_bitlen_o is tied to 0.
module acorn_ad_process
  import acorn_ad_process_pkg::*;
#(
  parameter int STATE_W   = ACORN_STATE_W,
  parameter int PAD_STEPS = ACORN_PAD_STEPS,
  parameter int CA_STEPS  = ACORN_CA_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               ad_empty_i,
  input  logic [STATE_W-1:0] state_in,
  input  logic               ad_valid_i,
  input  logic [7:0]         ad_data_i,
  input  logic               ad_last_i,
  output logic               ad_ready_o,
  output logic [STATE_W-1:0] state_out,
  output logic               busy_o,
  output logic               done_o,
  output logic [63:0]        ad_bitlen_o
);
  ad_state_e          r_state;
  ad_state_e          w_next;
  logic [STATE_W-1:0] r_sreg;
  logic [STATE_W-1:0] w_nstate;
  logic [7:0]         r_byte;
  logic               r_last;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_pad;
  logic               r_done;
  logic               w_start;
  logic               w_step;
  logic               w_mbit;
  logic               w_ca;
  logic               w_cb;
  assign w_start   = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign state_out = r_sreg;
  assign done_o    = r_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start_i ? (ad_empty_i ? S_PAD : S_WAIT_BYTE) : r_state;
      S_WAIT_BYTE:    w_next = ad_valid_i ? S_AD_BITS : S_WAIT_BYTE;
      S_AD_BITS:      w_next = r_bitcnt == 3'd7 ? (r_last ? S_PAD : S_WAIT_BYTE) : S_AD_BITS;
      S_PAD:          w_next = r_pad == 8'(PAD_STEPS - 1) ? S_DONE : S_PAD;
      default:        w_next = S_IDLE;
    endcase
  end
  always_comb begin
    ad_ready_o = r_state == S_WAIT_BYTE;
    busy_o     = r_state == S_WAIT_BYTE || r_state == S_AD_BITS || r_state == S_PAD;
    w_step     = r_state == S_AD_BITS || r_state == S_PAD;
    w_mbit     = r_state == S_AD_BITS ? r_byte[r_bitcnt] : r_pad == 8'd0;
    w_ca       = r_state == S_AD_BITS ? AD_CA : r_pad < 8'(CA_STEPS);
    w_cb       = AD_CB;
  end
  state_update128 u_round (
    .i_state(r_sreg),
    .i_mbit (w_mbit),
    .i_ca   (w_ca),
    .i_cb   (w_cb),
    .o_state(w_nstate)
  );
  // done_o trails DONE entry by one cycle and drops on the edge that restarts the phase.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sreg   <= '0;
      r_byte   <= '0;
      r_last   <= 1'b0;
      r_bitcnt <= '0;
      r_pad    <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_start) r_sreg <= state_in;
      else if (w_step) r_sreg <= w_nstate;
      if (w_start) r_pad <= '0;
      else if (r_state == S_PAD) r_pad <= r_pad + 8'd1;
      if (ad_ready_o && ad_valid_i) begin
        r_byte   <= ad_data_i;
        r_last   <= ad_last_i;
        r_bitcnt <= '0;
      end else if (r_state == S_AD_BITS) r_bitcnt <= r_bitcnt + 3'd1;
      r_done <= r_state == S_DONE && !start_i;
    end
`ifdef ACORN_AD_LENCOUNT_EN
  logic [63:0] r_bitlen;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_bitlen <= '0;
    else if (w_start) r_bitlen <= '0;
    else if (r_state == S_AD_BITS && r_bitlen != '1) r_bitlen <= r_bitlen + 64'd1;
  assign ad_bitlen_o = r_bitlen;
`else
  assign ad_bitlen_o = '0;
`endif
endmodule
